// File: rtl/cfgfrm_pkg.sv
// Shared constants, state encoding and helpers for the config-frame sequencer.
package cfgfrm_pkg;

  localparam int         PAYLOAD_LEN = 24;
  localparam logic [7:0] FRM_HEAD    = 8'hA5;
  localparam logic [7:0] FRM_TYPE    = 8'h3C;
  localparam int         TMO_CYC     = 1000;

  localparam int PTR_W = $clog2(PAYLOAD_LEN);
  localparam int TMO_W = $clog2(TMO_CYC);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PAYLOAD_LEN - 1);
  localparam logic [7:0]       LEN_BYTE = 8'(PAYLOAD_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  // One-hot FSM encoding
  localparam logic [6:0] ST_IDLE   = 7'b000_0001;
  localparam logic [6:0] ST_TYPE   = 7'b000_0010;
  localparam logic [6:0] ST_LEN    = 7'b000_0100;
  localparam logic [6:0] ST_PAYLD  = 7'b000_1000;
  localparam logic [6:0] ST_CSUM   = 7'b001_0000;
  localparam logic [6:0] ST_REPLAY = 7'b010_0000;
  localparam logic [6:0] ST_GAP    = 7'b100_0000;

  // Saturating 8-bit increment for the error counter
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cfgfrm_if.sv
// Serial-link byte input and loader-side outputs of the config-frame sequencer.
interface cfgfrm_if;
  logic       slink_rx_vld;
  logic [7:0] slink_rx_data;
  logic       cfg_param_dval;
  logic [7:0] slink_cfg_data;
  logic       cfg_done;
  logic       err_type;
  logic       err_len;
  logic       err_csum;
  logic       err_tmo;
  logic       err_ovr;
  logic [7:0] frm_ok_cnt;
  logic [7:0] frm_err_cnt;

  modport slave (
    input  slink_rx_vld, slink_rx_data,
    output cfg_param_dval, slink_cfg_data, cfg_done,
           err_type, err_len, err_csum, err_tmo, err_ovr,
           frm_ok_cnt, frm_err_cnt
  );

  modport master (
    output slink_rx_vld, slink_rx_data,
    input  cfg_param_dval, slink_cfg_data, cfg_done,
           err_type, err_len, err_csum, err_tmo, err_ovr,
           frm_ok_cnt, frm_err_cnt
  );
endinterface

// File: rtl/cfgfrm_buf.sv
// Payload buffer: PAYLOAD_LEN x 8 registers, one write port, registered read port.
// rdata returns 0 when re is low so it can drive the loader byte directly.
module cfgfrm_buf
  import cfgfrm_pkg::*;
(
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [7:0]       wdata,
  input  logic             re,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [PAYLOAD_LEN];

  // Storage: contents are only meaningful after a full payload is written
  always_ff @(posedge clk_sys) begin
    if (we) mem[wr_ptr] <= wdata;
  end

  // Registered read, zero outside the replay burst
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) rdata <= '0;
    else            rdata <= re ? mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/cfgfrm_seq.sv
// Config-frame sequencer: validates A5/type/len/payload/csum frames from the
// serial link and replays verified payloads to the loader as one burst.
module cfgfrm_seq
  import cfgfrm_pkg::*;
(
  input  logic     clk_sys,
  input  logic     rst_sys_n,
  cfgfrm_if.slave  bus
);

  logic [6:0]       st, st_nx;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]       acc;
  logic [TMO_W-1:0] tmo;
  logic             vld;
  logic [7:0]       din;
  logic             timed, tmo_hit, csum_ok, rep_end, re, we;
  logic             e_type, e_len, e_csum, e_ovr, any_err;
  logic             dval_q, done_q, et_q, el_q, ec_q, eto_q, eo_q;
  logic [7:0]       ok_cnt, err_cnt, rdata;

  assign vld     = bus.slink_rx_vld;
  assign din     = bus.slink_rx_data;
  assign timed   = |(st & (ST_TYPE | ST_LEN | ST_PAYLD | ST_CSUM));
  assign tmo_hit = timed && !vld && (tmo == TMO_LAST);
  assign csum_ok = (st == ST_CSUM) && vld && (din == acc);
  // Replay entry leaves rd_ptr at 1, so 0 inside REPLAY means it wrapped
  assign rep_end = (st == ST_REPLAY) && (rd_ptr == '0);
  assign re      = csum_ok || ((st == ST_REPLAY) && !rep_end);
  assign we      = (st == ST_PAYLD) && vld;
  assign any_err = e_type | e_len | e_csum | e_ovr | tmo_hit;

  // Next-state and error-pulse decode
  always_comb begin
    st_nx  = st;
    e_type = 1'b0;
    e_len  = 1'b0;
    e_csum = 1'b0;
    e_ovr  = 1'b0;
    case (st)
      ST_IDLE:   if (vld && din == FRM_HEAD) st_nx = ST_TYPE;
      ST_TYPE:   if (vld) begin
                   if (din == FRM_TYPE) st_nx = ST_LEN;
                   else begin e_type = 1'b1; st_nx = ST_IDLE; end
                 end
      ST_LEN:    if (vld) begin
                   if (din == LEN_BYTE) st_nx = ST_PAYLD;
                   else begin e_len = 1'b1; st_nx = ST_IDLE; end
                 end
      ST_PAYLD:  if (vld && wr_ptr == PTR_LAST) st_nx = ST_CSUM;
      ST_CSUM:   if (vld) begin
                   if (csum_ok) st_nx = ST_REPLAY;
                   else begin e_csum = 1'b1; st_nx = ST_IDLE; end
                 end
      ST_REPLAY: begin
                   e_ovr = vld;
                   if (rep_end) st_nx = ST_GAP;
                 end
      ST_GAP:    begin
                   e_ovr = vld;
                   st_nx = ST_IDLE;
                 end
      default:   st_nx = ST_IDLE;
    endcase
    if (tmo_hit) st_nx = ST_IDLE;
  end

  // FSM, pointers, checksum and inter-byte timeout
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      st     <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      acc    <= '0;
      tmo    <= '0;
    end else begin
      st <= st_nx;
      if (st_nx == ST_IDLE)  wr_ptr <= '0;
      else if (we)           wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (re)                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (vld) begin
        case (st)
          ST_TYPE:           acc <= din;
          ST_LEN, ST_PAYLD:  acc <= acc + din;
          default:           ;
        endcase
      end
      if (!timed || vld || tmo_hit || st_nx != st) tmo <= '0;
      else                                         tmo <= tmo + 1'b1;
    end
  end

  // Registered status outputs and frame counters
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      dval_q  <= 1'b0;
      done_q  <= 1'b0;
      et_q    <= 1'b0;
      el_q    <= 1'b0;
      ec_q    <= 1'b0;
      eto_q   <= 1'b0;
      eo_q    <= 1'b0;
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      dval_q <= re;
      done_q <= rep_end;
      et_q   <= e_type;
      el_q   <= e_len;
      ec_q   <= e_csum;
      eto_q  <= tmo_hit;
      eo_q   <= e_ovr;
      if (rep_end) ok_cnt  <= ok_cnt + 8'd1;
      if (any_err) err_cnt <= sat_inc(err_cnt);
    end
  end

  cfgfrm_buf u_buf (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .we        (we),
    .wr_ptr    (wr_ptr),
    .wdata     (din),
    .re        (re),
    .rd_ptr    (rd_ptr),
    .rdata     (rdata)
  );

  assign bus.cfg_param_dval = dval_q;
  assign bus.slink_cfg_data = rdata;
  assign bus.cfg_done       = done_q;
  assign bus.err_type       = et_q;
  assign bus.err_len        = el_q;
  assign bus.err_csum       = ec_q;
  assign bus.err_tmo        = eto_q;
  assign bus.err_ovr        = eo_q;
  assign bus.frm_ok_cnt     = ok_cnt;
  assign bus.frm_err_cnt    = err_cnt;

endmodule

// File: tb/tb_cfgfrm_seq.sv
// Scoreboard bench for cfgfrm_seq: a frame-level parser predicts bursts and
// status events; a negedge monitor pops and compares whatever the DUT emits.
module tb_cfgfrm_seq;
  import cfgfrm_pkg::*;

  localparam int EV_DONE = 0, EV_TYPE = 1, EV_LEN = 2, EV_CSUM = 3, EV_TMO = 4, EV_OVR = 5;

  typedef struct { int kind; int val; } ev_t;

  logic clk_sys   = 1'b0;
  logic rst_sys_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  cfgfrm_if bus();

  cfgfrm_seq dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .bus       (bus)
  );

  logic [7:0] data_q[$];
  ev_t        ev_q[$];
  logic [7:0] seg[$];
  int n_cmp = 0, n_bad = 0;
  int m_ok = 0, m_err = 0;
  int cyc = 0, tmo_edge = 0, run = 0;
  logic prev_dval = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic exp_err(input int kind);
    if (m_err < 255) m_err++;
    ev_q.push_back('{kind, m_err});
  endtask

  // Parse a complete byte segment by position: header hunt, then type, len,
  // payload and mod-256 checksum; verified payloads become expected bursts.
  task automatic model_seg();
    int i = 0;
    logic [7:0] sum;
    while (i < seg.size()) begin
      if (seg[i] != FRM_HEAD) begin i++; continue; end
      if (seg[i+1] != FRM_TYPE) begin exp_err(EV_TYPE); i += 2; continue; end
      if (seg[i+2] != LEN_BYTE) begin exp_err(EV_LEN); i += 3; continue; end
      sum = seg[i+1] + seg[i+2];
      for (int j = 0; j < PAYLOAD_LEN; j++) sum = sum + seg[i+3+j];
      if (seg[i+3+PAYLOAD_LEN] != sum) exp_err(EV_CSUM);
      else begin
        for (int j = 0; j < PAYLOAD_LEN; j++) data_q.push_back(seg[i+3+j]);
        m_ok = (m_ok + 1) % 256;
        ev_q.push_back('{EV_DONE, m_ok});
      end
      i += PAYLOAD_LEN + 4;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic [7:0] b, input int gap);
    bus.slink_rx_vld  = 1'b1;
    bus.slink_rx_data = b;
    @(negedge clk_sys);
    bus.slink_rx_vld  = 1'b0;
    bus.slink_rx_data = 8'h00;
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic add_junk(input int n);
    logic [7:0] b;
    for (int j = 0; j < n; j++) begin
      b = 8'($urandom_range(0, 255));
      if (b == FRM_HEAD) b = 8'h00;
      seg.push_back(b);
    end
  endtask

  task automatic add_frame(input bit seq_pl, input int csum_off);
    logic [7:0] s, b;
    s = FRM_TYPE + LEN_BYTE;
    seg.push_back(FRM_HEAD); seg.push_back(FRM_TYPE); seg.push_back(LEN_BYTE);
    for (int j = 0; j < PAYLOAD_LEN; j++) begin
      b = seq_pl ? 8'(j + 1) : 8'($urandom_range(0, 255));
      seg.push_back(b);
      s = s + b;
    end
    seg.push_back(s + 8'(csum_off));
  endtask

  task automatic send_seg(input int last_gap, input bit rnd_gap);
    for (int j = 0; j < seg.size() - 1; j++)
      put(seg[j], rnd_gap ? $urandom_range(0, 3) : 0);
    put(seg[seg.size()-1], last_gap);
  endtask

  task automatic issue(input bit rnd_gap);
    model_seg();
    send_seg(26, rnd_gap);
  endtask

  // ---------------- monitor ----------------
  task automatic obs_ev(input logic hit, input string name, input int kind, input int cnt);
    ev_t e;
    if (hit) begin
      chk({name, "_expected"}, int'(ev_q.size() > 0), 1);
      if (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        chk({name, "_kind"}, kind, e.kind);
        chk({name, "_cnt"}, cnt, e.val);
        if (kind == EV_TMO) chk("tmo_latency", cyc - tmo_edge, TMO_CYC);
      end
    end
  endtask

  always @(negedge clk_sys) begin
    if (!rst_sys_n) begin
      run = 0;
      prev_dval = 1'b0;
    end else begin
      if (bus.cfg_param_dval) begin
        run++;
        chk("burst_expected", int'(data_q.size() > 0), 1);
        if (data_q.size() > 0) chk("burst_byte", bus.slink_cfg_data, data_q.pop_front());
      end else if (prev_dval) begin
        chk("burst_len", run, PAYLOAD_LEN);
        chk("done_after_burst", bus.cfg_done, 1);
        chk("idle_data_zero", bus.slink_cfg_data, 0);
        run = 0;
      end
      prev_dval = bus.cfg_param_dval;
      obs_ev(bus.cfg_done, "cfg_done", EV_DONE, bus.frm_ok_cnt);
      obs_ev(bus.err_type, "err_type", EV_TYPE, bus.frm_err_cnt);
      obs_ev(bus.err_len,  "err_len",  EV_LEN,  bus.frm_err_cnt);
      obs_ev(bus.err_csum, "err_csum", EV_CSUM, bus.frm_err_cnt);
      obs_ev(bus.err_tmo,  "err_tmo",  EV_TMO,  bus.frm_err_cnt);
      obs_ev(bus.err_ovr,  "err_ovr",  EV_OVR,  bus.frm_err_cnt);
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_dval"}, bus.cfg_param_dval, 0);
    chk({tag, "_data"}, bus.slink_cfg_data, 0);
    chk({tag, "_done"}, bus.cfg_done, 0);
    chk({tag, "_errs"}, {bus.err_type, bus.err_len, bus.err_csum, bus.err_tmo, bus.err_ovr}, 0);
    chk({tag, "_ok_cnt"}, bus.frm_ok_cnt, 0);
    chk({tag, "_err_cnt"}, bus.frm_err_cnt, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    ev_t d;
    logic [7:0] b;
    bus.slink_rx_vld  = 1'b0;
    bus.slink_rx_data = 8'h00;
    repeat (3) @(negedge clk_sys);
    chk_idle_outputs("in_reset");
    #2 rst_sys_n = 1'b1;
    @(negedge clk_sys);
    chk_idle_outputs("after_reset");

    // Good frame with payload 01..18
    seg.delete(); add_frame(1, 0); issue(0);

    // Header hunt: junk before a good frame
    seg.delete(); seg.push_back(8'h00); seg.push_back(8'hFF); seg.push_back(8'h5A);
    add_frame(1, 0); issue(0);

    // Bad checksum then a good frame
    seg.delete(); add_frame(1, 1); issue(0);
    seg.delete(); add_frame(1, 0); issue(0);

    // Bad type and bad length, with trailing bytes hunted silently
    seg.delete(); seg.push_back(FRM_HEAD); seg.push_back(8'h3D); add_junk(5); issue(0);
    seg.delete(); seg.push_back(FRM_HEAD); seg.push_back(FRM_TYPE); seg.push_back(8'h17); add_junk(5); issue(0);

    // Timeout after 10 payload bytes
    put(FRM_HEAD, 0); put(FRM_TYPE, 0); put(LEN_BYTE, 0);
    for (int j = 0; j < 10; j++) put(8'($urandom_range(0, 255)), 0);
    tmo_edge = cyc;
    exp_err(EV_TMO);
    repeat (1010) @(negedge clk_sys);
    seg.delete(); add_frame(0, 0); issue(0);

    // Randomized mix of junk, good and corrupted frames
    for (int n = 0; n < 40; n++) begin
      seg.delete();
      case ($urandom_range(0, 4))
        0: add_junk($urandom_range(1, 4));
        1: add_frame(0, 0);
        2: add_frame(0, $urandom_range(1, 255));
        3: begin
             b = 8'($urandom_range(0, 255));
             if (b == FRM_TYPE) b = 8'h3D;
             seg.push_back(FRM_HEAD); seg.push_back(b); add_junk($urandom_range(0, 3));
           end
        default: begin
             b = 8'($urandom_range(0, 255));
             if (b == LEN_BYTE) b = 8'h17;
             seg.push_back(FRM_HEAD); seg.push_back(FRM_TYPE); seg.push_back(b);
             add_junk($urandom_range(0, 3));
           end
      endcase
      issue(1);
    end

    // Overrun: a byte strobed during replay cycle 5 leaves the burst intact
    seg.delete(); add_frame(0, 0);
    model_seg();
    d = ev_q.pop_back();
    exp_err(EV_OVR);
    ev_q.push_back(d);
    send_seg(4, 0);
    put(8'h77, 30);

    // Error counter saturation
    for (int n = 0; n < 260; n++) begin
      b = 8'($urandom_range(0, 255));
      if (b == FRM_TYPE) b = 8'h00;
      exp_err(EV_TYPE);
      put(FRM_HEAD, 0);
      put(b, 0);
    end
    repeat (5) @(negedge clk_sys);

    // Reset at replay cycle 10 drops dval at once and clears counters
    seg.delete(); add_frame(0, 0);
    model_seg();
    send_seg(9, 0);
    #2 rst_sys_n = 1'b0;
    #1;
    chk("rst_burst_remaining", data_q.size(), PAYLOAD_LEN - 10);
    chk_idle_outputs("mid_burst_reset");
    data_q.delete();
    ev_q.delete();
    m_ok = 0;
    m_err = 0;
    repeat (2) @(negedge clk_sys);
    #2 rst_sys_n = 1'b1;
    @(negedge clk_sys);
    seg.delete(); add_frame(1, 0); issue(0);

    repeat (40) @(negedge clk_sys);
    chk("data_q_drained", data_q.size(), 0);
    chk("ev_q_drained", ev_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
